// File: rtl/lq_agen_sched.sv
// Address-generation scheduler: arbitrates three requesters onto one
// two-stage EA adder (operand latch, then byte-wise carry-select sums).
module lq_agen_sched #(
    parameter int EA_WIDTH  = 64,
    parameter int TAG_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  flush,
    input  logic                  req0_val,
    input  logic                  req1_val,
    input  logic                  req2_val,
    output logic                  req0_rdy,
    output logic                  req1_rdy,
    output logic                  req2_rdy,
    input  logic [0:EA_WIDTH-1]   req0_base,
    input  logic [0:EA_WIDTH-1]   req0_offset,
    input  logic [0:EA_WIDTH-1]   req1_base,
    input  logic [0:EA_WIDTH-1]   req1_offset,
    input  logic [0:EA_WIDTH-1]   req2_base,
    input  logic [0:EA_WIDTH-1]   req2_offset,
    input  logic                  req0_mode32,
    input  logic                  req1_mode32,
    input  logic                  req2_mode32,
    input  logic [TAG_WIDTH-1:0]  req0_tag,
    input  logic [TAG_WIDTH-1:0]  req1_tag,
    input  logic [TAG_WIDTH-1:0]  req2_tag,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [0:EA_WIDTH-1]   out_ea,
    output logic                  out_co,
    output logic [1:0]            out_src,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int NB = EA_WIDTH / 8;

    // Operand latch (S1)
    logic                 s1_v_q, s1_v_d;
    logic [0:EA_WIDTH-1]  s1_base_q, s1_base_d;
    logic [0:EA_WIDTH-1]  s1_off_q, s1_off_d;
    logic                 s1_m32_q, s1_m32_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic [1:0]           s1_src_q, s1_src_d;

    // Byte sums (S2); byte 0 is the most significant byte
    logic                 s2_v_q, s2_v_d;
    logic [7:0]           s2_sum0_q [NB];
    logic [7:0]           s2_sum0_d [NB];
    logic [7:0]           s2_sum1_q [NB];
    logic [7:0]           s2_sum1_d [NB];
    logic [0:NB-1]        s2_c0_q, s2_c0_d;
    logic [0:NB-1]        s2_c1_q, s2_c1_d;
    logic                 s2_m32_q, s2_m32_d;
    logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
    logic [1:0]           s2_src_q, s2_src_d;

    // rr_q = 0 prefers req1, 1 prefers req2
    logic                 rr_q, rr_d;

    logic                 s1_adv;
    logic                 s1_open;
    logic                 carry;

    assign s1_adv   = !s2_v_q || out_rdy;
    assign s1_open  = (!s1_v_q || s1_adv) && !flush;
    assign req0_rdy = s1_open && req0_val;
    assign req1_rdy = s1_open && !req0_val && req1_val && (!req2_val || !rr_q);
    assign req2_rdy = s1_open && !req0_val && req2_val && (!req1_val || rr_q);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        s1_v_d    = s1_v_q;
        s1_base_d = s1_base_q;
        s1_off_d  = s1_off_q;
        s1_m32_d  = s1_m32_q;
        s1_tag_d  = s1_tag_q;
        s1_src_d  = s1_src_q;
        rr_d      = rr_q;
        if (req0_rdy) begin
            s1_v_d    = 1'b1;
            s1_base_d = req0_base;
            s1_off_d  = req0_offset;
            s1_m32_d  = req0_mode32;
            s1_tag_d  = req0_tag;
            s1_src_d  = 2'd0;
        end else if (req1_rdy) begin
            s1_v_d    = 1'b1;
            s1_base_d = req1_base;
            s1_off_d  = req1_offset;
            s1_m32_d  = req1_mode32;
            s1_tag_d  = req1_tag;
            s1_src_d  = 2'd1;
            rr_d      = 1'b1;
        end else if (req2_rdy) begin
            s1_v_d    = 1'b1;
            s1_base_d = req2_base;
            s1_off_d  = req2_offset;
            s1_m32_d  = req2_mode32;
            s1_tag_d  = req2_tag;
            s1_src_d  = 2'd2;
            rr_d      = 1'b0;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
        if (flush) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        s2_v_d    = s2_v_q;
        s2_sum0_d = s2_sum0_q;
        s2_sum1_d = s2_sum1_q;
        s2_c0_d   = s2_c0_q;
        s2_c1_d   = s2_c1_q;
        s2_m32_d  = s2_m32_q;
        s2_tag_d  = s2_tag_q;
        s2_src_d  = s2_src_q;
        if (s1_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                for (int i = 0; i < NB; i++) begin
                    {s2_c0_d[i], s2_sum0_d[i]} = 9'(s1_base_q[8*i +: 8]) + 9'(s1_off_q[8*i +: 8]);
                    {s2_c1_d[i], s2_sum1_d[i]} = 9'(s1_base_q[8*i +: 8]) + 9'(s1_off_q[8*i +: 8]) + 9'd1;
                end
                s2_m32_d = s1_m32_q;
                s2_tag_d = s1_tag_q;
                s2_src_d = s1_src_q;
            end
        end
        if (flush) begin
            s2_v_d = 1'b0;
        end
    end

    // Carry-select resolve: walk from the least-significant byte toward byte 0
    always_comb begin
        carry  = 1'b0;
        out_ea = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            out_ea[8*i +: 8] = carry ? s2_sum1_q[i] : s2_sum0_q[i];
            carry            = carry ? s2_c1_q[i] : s2_c0_q[i];
        end
        out_co = carry;
        if (s2_m32_q) begin
            out_ea[0:31] = '0;
        end
    end

    assign out_val = s2_v_q;
    assign out_src = s2_src_q;
    assign out_tag = s2_tag_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_b) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            rr_q     <= 1'b0;
            s2_c0_q  <= '0;
            s2_c1_q  <= '0;
            s2_m32_q <= 1'b0;
            s2_tag_q <= '0;
            s2_src_q <= '0;
            for (int i = 0; i < NB; i++) begin
                s2_sum0_q[i] <= '0;
                s2_sum1_q[i] <= '0;
            end
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            rr_q      <= rr_d;
            s2_sum0_q <= s2_sum0_d;
            s2_sum1_q <= s2_sum1_d;
            s2_c0_q   <= s2_c0_d;
            s2_c1_q   <= s2_c1_d;
            s2_m32_q  <= s2_m32_d;
            s2_tag_q  <= s2_tag_d;
            s2_src_q  <= s2_src_d;
        end
    end

    // NOTE: S1 payload is qualified by s1_v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_base_q <= s1_base_d;
        s1_off_q  <= s1_off_d;
        s1_m32_q  <= s1_m32_d;
        s1_tag_q  <= s1_tag_d;
        s1_src_q  <= s1_src_d;
    end

endmodule

// File: tb/tb_lq_agen_sched.sv
// Bench for lq_agen_sched: directed scenarios then random traffic, checked
// every cycle against an in-order queue model of the scheduler.
module tb_lq_agen_sched;

    localparam int EA_WIDTH  = 64;
    localparam int TAG_WIDTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_b, flush, out_rdy;
    logic                 req_val  [3];
    logic                 req_rdy  [3];
    logic [0:EA_WIDTH-1]  req_base [3];
    logic [0:EA_WIDTH-1]  req_off  [3];
    logic                 req_m32  [3];
    logic [TAG_WIDTH-1:0] req_tag  [3];
    logic                 out_val, out_co;
    logic [0:EA_WIDTH-1]  out_ea;
    logic [1:0]           out_src;
    logic [TAG_WIDTH-1:0] out_tag;

    lq_agen_sched #(.EA_WIDTH(EA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk(clk), .rst_b(rst_b), .flush(flush),
        .req0_val(req_val[0]), .req1_val(req_val[1]), .req2_val(req_val[2]),
        .req0_rdy(req_rdy[0]), .req1_rdy(req_rdy[1]), .req2_rdy(req_rdy[2]),
        .req0_base(req_base[0]), .req0_offset(req_off[0]),
        .req1_base(req_base[1]), .req1_offset(req_off[1]),
        .req2_base(req_base[2]), .req2_offset(req_off[2]),
        .req0_mode32(req_m32[0]), .req1_mode32(req_m32[1]), .req2_mode32(req_m32[2]),
        .req0_tag(req_tag[0]), .req1_tag(req_tag[1]), .req2_tag(req_tag[2]),
        .out_val(out_val), .out_rdy(out_rdy), .out_ea(out_ea), .out_co(out_co),
        .out_src(out_src), .out_tag(out_tag)
    );

    typedef struct {
        logic [63:0] ea;
        logic        co;
        logic [1:0]  src;
        logic [3:0]  tag;
        int          age;
    } exp_t;

    exp_t q[$];
    int   pref;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 4))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return {32'h0, $urandom};
            2:       return 64'(1);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic set_req(input int n, input logic v, input logic [63:0] b, input logic [63:0] o,
                           input logic m, input logic [3:0] t);
        req_val[n]  = v;
        req_base[n] = b;
        req_off[n]  = o;
        req_m32[n]  = m;
        req_tag[n]  = t;
    endtask

    task automatic set_rand(input int n, input logic v);
        set_req(n, v, rand64(), rand64(), 1'($urandom_range(0, 3) == 0), 4'($urandom));
    endtask

    task automatic idle();
        for (int n = 0; n < 3; n++) req_val[n] = 1'b0;
    endtask

    // One clock: check grants/outputs at negedge, then advance the model at posedge.
    task automatic tick();
        logic        exp_val, acc, gnt;
        int          gid;
        logic [64:0] sum;
        exp_t        e;
        @(negedge clk);
        exp_val = (q.size() > 0) && (q[0].age >= 1);
        acc     = !flush && ((q.size() < 2) || (exp_val && out_rdy));
        gnt     = acc && (req_val[0] || req_val[1] || req_val[2]);
        gid     = req_val[0] ? 0 : (req_val[1] && req_val[2]) ? pref : req_val[1] ? 1 : 2;
        if (rst_b) begin
            check("rdy0", 64'(req_rdy[0]), 64'(gnt && gid == 0));
            check("rdy1", 64'(req_rdy[1]), 64'(gnt && gid == 1));
            check("rdy2", 64'(req_rdy[2]), 64'(gnt && gid == 2));
            check("out_val", 64'(out_val), 64'(exp_val));
            check("rr_pref", dut.rr_q ? 64'd2 : 64'd1, 64'(pref));
            if (exp_val) begin
                check("out_ea", out_ea, q[0].ea);
                check("out_co", 64'(out_co), 64'(q[0].co));
                check("out_src", 64'(out_src), 64'(q[0].src));
                check("out_tag", 64'(out_tag), 64'(q[0].tag));
            end
        end
        if (gnt) begin
            sum   = {1'b0, req_base[gid]} + {1'b0, req_off[gid]};
            e.co  = sum[64];
            e.ea  = req_m32[gid] ? {32'h0, sum[31:0]} : sum[63:0];
            e.src = 2'(gid);
            e.tag = req_tag[gid];
            e.age = 0;
        end
        @(posedge clk);
        if (!rst_b) begin
            q.delete();
            pref = 1;
        end else begin
            if (exp_val && out_rdy) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (flush) q.delete();
            if (gnt) begin
                q.push_back(e);
                if (gid == 1) pref = 2;
                else if (gid == 2) pref = 1;
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_out_ea", out_ea, 64'd0);
        check("rst_out_co", 64'(out_co), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
    endtask

    initial begin
        pref    = 1;
        rst_b   = 1'b0;
        flush   = 1'b0;
        out_rdy = 1'b1;
        for (int n = 0; n < 3; n++) set_req(n, 1'b0, 64'd0, 64'd0, 1'b0, 4'd0);

        // Reset
        tick();
        tick();
        check_reset_outputs();
        rst_b = 1'b1;

        // Single req1: 0xFF + 1
        set_req(1, 1'b1, 64'hFF, 64'h1, 1'b0, 4'd3);
        tick();
        idle();
        tick();
        check("single_val", 64'(out_val), 64'd1);
        check("single_ea", out_ea, 64'h100);
        check("single_co", 64'(out_co), 64'd0);
        check("single_src", 64'(out_src), 64'd1);
        check("single_tag", 64'(out_tag), 64'd3);
        tick();
        tick();

        // Full carry ripple, with and without mode32
        set_req(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'd1);
        tick();
        set_req(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 4'd2);
        tick();
        set_req(0, 1'b1, 64'h1_8000_0000, 64'h8000_0000, 1'b1, 4'd4);
        tick();
        idle();
        repeat (3) tick();

        // All three contending, then req1/req2 alternation
        for (int n = 0; n < 3; n++) set_rand(n, 1'b1);
        repeat (6) tick();
        req_val[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_rand(1, 1'b1);
            set_rand(2, 1'b1);
            tick();
        end
        idle();
        repeat (3) tick();

        // Back-pressure for 5 cycles, then release
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_rand(1, 1'b1);
            set_rand(2, 1'b1);
            tick();
        end
        out_rdy = 1'b1;
        repeat (3) tick();
        idle();
        repeat (3) tick();

        // Flush with both stages full
        out_rdy = 1'b0;
        set_rand(2, 1'b1);
        tick();
        set_rand(2, 1'b1);
        tick();
        flush = 1'b1;
        set_rand(1, 1'b1);
        tick();
        flush   = 1'b0;
        out_rdy = 1'b1;
        idle();
        tick();
        set_rand(1, 1'b1);
        tick();
        idle();
        repeat (3) tick();

        // Reset mid-operation, then req1 vs req2 tie
        out_rdy = 1'b0;
        set_rand(2, 1'b1);
        repeat (3) tick();
        rst_b = 1'b0;
        tick();
        check_reset_outputs();
        rst_b   = 1'b1;
        out_rdy = 1'b1;
        set_rand(1, 1'b1);
        set_rand(2, 1'b1);
        tick();
        check("tie_after_reset", 64'(q.size() == 1 && q[0].src == 2'd1), 64'd1);
        idle();
        repeat (3) tick();

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < 3; n++) set_rand(n, 1'($urandom_range(0, n == 0 ? 4 : 1) == 0));
            out_rdy = 1'($urandom_range(0, 3) != 0);
            flush   = 1'($urandom_range(0, 19) == 0);
            tick();
        end
        flush   = 1'b0;
        out_rdy = 1'b1;
        idle();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
